// File: rtl/ssp_pkg.sv
// Shared definitions for the SSSP accelerator DRAM port arbiters.
// Holds bus widths, requester slots and the read-arbiter state encoding.
package ssp_pkg;

    localparam int SSP_AW   = 32;
    localparam int SSP_DW   = 1024;
    localparam int SSP_WW   = 32;
    localparam int SSP_NCLI = 4;
    localparam int SSP_SW   = 5;

    localparam int CLI_MAP   = 0;
    localparam int CLI_PACK  = 1;
    localparam int CLI_DIST  = 2;
    localparam int CLI_SPARE = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RESP      = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ssp_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Shared by the read and write DRAM port arbiters.
module ssp_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] cand;

    // Scan farthest offset first so the nearest requester overwrites.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int o = N - 1; o >= 0; o--) begin
            cand = {1'b0, ptr} + (IW + 1)'(o);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                gnt                 = '0;
                gnt[cand[IW-1:0]]   = 1'b1;
                idx                 = cand[IW-1:0];
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssp_rd_port_arbiter.sv
// Round-robin arbiter sharing the single DRAM read port between the
// SSSP requesters; returns the line and one selected word per request.
module ssp_rd_port_arbiter
    import ssp_pkg::*;
#(
    parameter int NCLI = SSP_NCLI,
    parameter int AW   = SSP_AW,
    parameter int DW   = SSP_DW,
    parameter int WW   = SSP_WW,
    parameter int TMO  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCLI-1:0]   req,
    input  logic [NCLI*AW-1:0] req_addr,
    input  logic [NCLI*5-1:0] req_sel,
    output logic [NCLI-1:0]   gnt,
    output logic [NCLI-1:0]   resp_valid,
    output logic [DW-1:0]     resp_line,
    output logic [WW-1:0]     resp_word,
    output logic [AW-1:0]     raddr,
    output logic              renable,
    input  logic              rready,
    input  logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              tmo_err
);

    localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int SW = SSP_SW;
    localparam int TW = $clog2(TMO + 1);

    rd_state_e state, state_nx;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   cli;
    logic [SW-1:0]   sel;
    logic            low_seen;
    logic [TW-1:0]   wd;

    logic [NCLI-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            do_grant;
    logic            do_cap;
    logic            do_tmo;
    logic            wd_hit;

    ssp_rr_pick #(
        .N  (NCLI),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_cap   = 1'b0;
        do_tmo   = 1'b0;
        wd_hit   = (wd == TW'(TMO - 1));
        unique case (state)
            ST_IDLE: begin
                if (rready && pick_any) begin
                    do_grant = 1'b1;
                    state_nx = ST_WAIT_LOW;
                end
            end
            // A second high cycle means accept and data came together.
            ST_WAIT_LOW: begin
                if (wd_hit) begin
                    do_tmo   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (!rready || low_seen) begin
                    state_nx = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (rready) begin
                    do_cap   = 1'b1;
                    state_nx = ST_RESP;
                end else if (wd_hit) begin
                    do_tmo   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cli        <= '0;
            sel        <= '0;
            low_seen   <= 1'b0;
            wd         <= '0;
            gnt        <= '0;
            resp_valid <= '0;
            resp_line  <= '0;
            resp_word  <= '0;
            raddr      <= '0;
            renable    <= 1'b0;
            busy       <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            gnt        <= '0;
            renable    <= 1'b0;
            resp_valid <= '0;
            if (do_grant) begin
                gnt      <= pick_gnt;
                renable  <= 1'b1;
                raddr    <= req_addr[int'(pick_idx)*AW +: AW];
                sel      <= req_sel[int'(pick_idx)*SW +: SW];
                cli      <= pick_idx;
                busy     <= 1'b1;
                wd       <= '0;
                low_seen <= 1'b0;
                rr_ptr   <= (pick_idx == IW'(NCLI - 1)) ? '0
                                                         : pick_idx + 1'b1;
            end
            if (state == ST_WAIT_LOW || state == ST_WAIT_DATA) begin
                wd <= wd + 1'b1;
            end
            if (state == ST_WAIT_LOW) begin
                low_seen <= 1'b1;
            end
            if (do_cap) begin
                resp_line       <= rdata;
                resp_word       <= rdata[int'(sel)*WW +: WW];
                resp_valid[cli] <= 1'b1;
            end
            if (do_tmo) begin
                tmo_err <= 1'b1;
                busy    <= 1'b0;
            end
            if (state == ST_RESP) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ssp_rd_port_arbiter.md
Name: ssp_rd_port_arbiter

Overview:
- Shares the single 1024-bit DRAM read port among the SSSP accelerator's read requesters: map lookup, packet fetch, distance-line fetch, and one spare.
- Grants one request at a time in round-robin order and drives the raddr/renable/rready handshake.
- Returns the full 1024-bit line plus a selected 32-bit word to the granted requester.
- Sits between the SSSP control FSMs and the DRAM controller's read port.

Parameters:
NCLI, 4, number of requesters
AW, 32, DRAM address width
DW, 1024, DRAM line width
WW, 32, width of the extracted word; DW/WW words per line
TMO, 4096, watchdog limit in cycles for one outstanding read

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NCLI  per-client request level; held until gnt
req_addr  in  NCLI*AW  per-client line address; client i at [i*AW +: AW]
req_sel  in  NCLI*5  per-client word index within the line
gnt  out  NCLI  one-hot, one-cycle pulse when the client's request is issued
resp_valid  out  NCLI  one-hot, one-cycle pulse when the data is ready
resp_line  out  DW  captured DRAM line; valid while resp_valid is high
resp_word  out  WW  resp_line[sel*WW +: WW] for the granted client's sel
raddr  out  AW  DRAM read address
renable  out  1  DRAM read strobe, one-cycle pulse
rready  in  1  DRAM ready; high = idle or data valid
rdata  in  DW  DRAM read data
busy  out  1  high from grant until resp_valid
tmo_err  out  1  sticky watchdog error

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=IDLE; internal latches 0. Reset mid-transaction aborts to IDLE immediately. A DRAM reply that arrives after reset is ignored.
- States: IDLE, WAIT_LOW, WAIT_DATA, RESP.
- IDLE: when rready=1 and |req, pick the first requesting client scanning rr_ptr, rr_ptr+1, … modulo NCLI.
  - Registered outputs next cycle: renable=1, raddr=req_addr[k], gnt[k]=1, busy=1.
  - Latch k and req_sel[k]; go to WAIT_LOW.
  - rr_ptr <= k+1 (wraps NCLI-1 -> 0).
  - Latency: req sampled at edge N gives renable/gnt high in cycle N+1.
- WAIT_LOW: renable returns to 0 after exactly one cycle. Wait for rready=0.
  - If rready is still 1 after 2 cycles, the controller is treated as having accepted and returned data together: go to WAIT_DATA.
- WAIT_DATA: on rready=1, capture rdata into resp_line, compute resp_word from the latched sel, go to RESP.
- RESP: resp_valid[k]=1 for one cycle; busy=0 on the following cycle; return to IDLE.
  - A new grant is possible in the cycle after RESP, so back-to-back issue spacing is at least 4 cycles.
- Watchdog: counter cleared at grant, increments in WAIT_LOW and WAIT_DATA.
  - Reaching TMO sets tmo_err and returns to IDLE without resp_valid.
  - tmo_err clears only on reset.
- Client rules:
  - req must stay high until gnt; dropping it earlier withdraws the request.
  - req_addr and req_sel are sampled only at the grant edge.
  - A client may re-request the cycle after its resp_valid; round-robin then favours the other clients.
- rready=0 in IDLE stalls arbitration; no grant is issued.
- Word select: sel in 0..31, offset sel*WW. No bound check is needed for DW=1024, WW=32.
- raddr stays stable from grant until the next grant.

Decomposition:
- Shared package ssp_pkg:
  - SSP_AW=32, SSP_DW=1024, SSP_WW=32
  - client index constants CLI_MAP=0, CLI_PACK=1, CLI_DIST=2, CLI_SPARE=3
  - state encoding typedef for the arbiter FSM
- One natural sub-module: ssp_rr_pick, a combinational round-robin priority picker (req, ptr -> one-hot grant and index). Reused later by the write-port arbiter.

Test Plan:
- Single request, DRAM model (rready low 3 cycles after renable): req[0]=1, addr=0x100, sel=3, line with word3=0xDEADBEEF -> renable pulse one cycle after req with raddr=0x100 and gnt=0001; resp_valid=0001 with resp_word=0xDEADBEEF; busy high throughout.
- All four requesting from reset -> grant order 0,1,2,3,0; each raddr matches its client; no overlapping renable.
- Client 2 re-requests immediately after its response while clients 0 and 3 wait -> next grants go to 3 then 0, then 2.
- rready held 0 in IDLE for 10 cycles with req[1]=1 -> no gnt or renable; grant occurs one cycle after rready rises.
- DRAM never returns (rready stuck 0) with TMO set to 16 -> tmo_err=1 after 16 cycles; no resp_valid; busy=0; next request is granted normally.
- reset asserted in WAIT_DATA -> all outputs 0 the same cycle; a late rready=1 does not produce resp_valid; rr_ptr=0.
